// File: rtl/rv32_rf_pkg.sv
// rtl/rv32_rf_pkg.sv - shared types and constants for the RV32 register file
//
// Contents:
//   rf_state_e      soft-clear FSM state (RF_IDLE, RF_CLEAR)
//   RF_DEPTH_E/I    legal register-file depths (RV32E = 16, RV32I = 32)
//   rf_depth_legal  depth legality test used at elaboration by the top

package rv32_rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DEPTH_E = 16;
  localparam int RF_DEPTH_I = 32;

  function automatic bit rf_depth_legal(input int n);
    return (n == RF_DEPTH_E) || (n == RF_DEPTH_I);
  endfunction

endpackage

// File: rtl/rv32_rf_scoreboard.sv
// rtl/rv32_rf_scoreboard.sv - pending-write scoreboard for the RV32 register file
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   flush               synchronous clear of every pending bit
//   set_en, set_addr    mark a destination pending (newly issued instruction)
//   clr_en, clr_addr    retire a pending destination (writeback)
//   clearing            soft clear in progress, forces both busy outputs high
//   rs1_addr, rs2_addr  source lookups
//   rs1_busy, rs2_busy  source has an outstanding write

module rv32_rf_scoreboard #(
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          clearing,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  // Bit 0 stays at its reset value of 0, so x0 is never pending.
  logic [NREGS-1:0] pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        // A set outranks a same-cycle clear: the newer instruction owns the register.
        if (set_en && set_addr == AW'(i)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_addr == AW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // A writeback landing this cycle is forwarded, so its destination is not busy.
  assign rs1_busy = clearing | (pending[rs1_addr] & ~(BYPASS & clr_en & (clr_addr == rs1_addr)));
  assign rs2_busy = clearing | (pending[rs2_addr] & ~(BYPASS & clr_en & (clr_addr == rs2_addr)));

endmodule

// File: rtl/rv32_regfile_sb.sv
// rtl/rv32_regfile_sb.sv - RV32 integer register file with scoreboard, bypass and soft clear
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   rs1_addr/rs2_addr           read addresses
//   rs1_data/rs2_data           combinational read data (x0 reads 0)
//   rs1_busy/rs2_busy           source pending or soft clear in progress
//   rd_addr/rd_data/rd_we       writeback port
//   iss_addr/iss_valid          mark the destination of an issued instruction pending
//   clr_req                     one-cycle pulse starting the sequential soft clear
//   clr_busy                    soft clear in progress

module rv32_regfile_sb
  import rv32_rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_we,
  input  logic [AW-1:0]   iss_addr,
  input  logic            iss_valid,
  input  logic            clr_req,
  output logic            clr_busy
);

  if (!rf_depth_legal(NREGS)) begin : g_bad_depth
    $error("rv32_regfile_sb: NREGS must be 16 or 32");
  end

  localparam bit BYP = (BYPASS != 0);

  rf_state_e       state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREGS];

  logic idle;
  logic wr_en;

  // Writeback and issue are only honoured while idle; the clear engine owns the file otherwise.
  assign idle  = (state == RF_IDLE);
  assign wr_en = idle && rd_we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RF_IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        RF_IDLE: begin
          for (int i = 1; i < NREGS; i++) begin
            if (wr_en && rd_addr == AW'(i)) begin
              regs[i] <= rd_data;
            end
          end
          if (clr_req) begin
            state    <= RF_CLEAR;
            clr_cnt  <= AW'(1);
            clr_busy <= 1'b1;
          end
        end
        RF_CLEAR: begin
          for (int i = 1; i < NREGS; i++) begin
            if (clr_cnt == AW'(i)) begin
              regs[i] <= '0;
            end
          end
          // Exit on the last register so the counter never wraps.
          if (clr_cnt == AW'(NREGS - 1)) begin
            state    <= RF_IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RF_IDLE;
          clr_cnt  <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 :
                    (BYP && wr_en && rd_addr == rs1_addr) ? rd_data : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 :
                    (BYP && wr_en && rd_addr == rs2_addr) ? rd_data : regs[rs2_addr];

  rv32_rf_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYP)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (idle && clr_req),
    .set_en   (idle && iss_valid && (iss_addr != '0)),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (rd_addr),
    .clearing (clr_busy),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_rv32_regfile_sb.sv
// tb/tb_rv32_regfile_sb.sv - scoreboard bench for rv32_regfile_sb (BYPASS=1 and BYPASS=0)

module tb_rv32_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, iss_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_we, iss_valid, clr_req;

  logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic            b_rs1_busy, b_rs2_busy, b_clr_busy;
  logic            n_rs1_busy, n_rs2_busy, n_clr_busy;

  always #5 clk = ~clk;

  rv32_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .iss_addr(iss_addr), .iss_valid(iss_valid),
    .clr_req(clr_req), .clr_busy(b_clr_busy)
  );

  rv32_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .iss_addr(iss_addr), .iss_valid(iss_valid),
    .clr_req(clr_req), .clr_busy(n_clr_busy)
  );

  typedef struct {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic            b1;
    logic            b2;
    logic            cb;
  } port_exp_t;

  typedef struct {
    port_exp_t byp;
    port_exp_t nob;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural contents, pending flags, and the list of
  // registers the soft clear still has to zero (one per cycle, in order).
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int              m_clr_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_clr_q.delete();
  endtask

  function automatic port_exp_t predict(input bit byp);
    port_exp_t e;
    bit clearing;
    bit f1, f2;
    clearing = (m_clr_q.size() != 0);
    f1 = byp && !clearing && rd_we && (rd_addr == rs1_addr) && (rs1_addr != 0);
    f2 = byp && !clearing && rd_we && (rd_addr == rs2_addr) && (rs2_addr != 0);
    e.d1 = (rs1_addr == 0) ? '0 : (f1 ? rd_data : m_regs[rs1_addr]);
    e.d2 = (rs2_addr == 0) ? '0 : (f2 ? rd_data : m_regs[rs2_addr]);
    e.b1 = clearing || ((rs1_addr != 0) && m_pend[rs1_addr] && !f1);
    e.b2 = clearing || ((rs2_addr != 0) && m_pend[rs2_addr] && !f2);
    e.cb = clearing;
    return e;
  endfunction

  task automatic model_edge();
    int r;
    if (m_clr_q.size() != 0) begin
      r = m_clr_q.pop_front();
      m_regs[r] = '0;
    end else begin
      if (rd_we && rd_addr != 0) begin
        m_regs[rd_addr] = rd_data;
        m_pend[rd_addr] = 1'b0;
      end
      if (clr_req) begin
        for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        for (int i = 1; i < NREGS; i++) m_clr_q.push_back(i);
      end else if (iss_valid && iss_addr != 0) begin
        m_pend[iss_addr] = 1'b1;
      end
    end
  endtask

  // One clock of stimulus: drive at the falling edge, queue the expected outputs,
  // then advance the model past the coming rising edge.
  task automatic cycle(input bit rn, input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit iv, input int ia, input bit cr, input int a1, input int a2);
    exp_t e;
    @(negedge clk);
    rst_n     = rn;
    rd_we     = rn ? we : 1'b0;
    rd_addr   = AW'(wa);
    rd_data   = wd;
    iss_valid = rn ? iv : 1'b0;
    iss_addr  = AW'(ia);
    clr_req   = rn ? cr : 1'b0;
    rs1_addr  = AW'(a1);
    rs2_addr  = AW'(a2);
    if (!rn) model_reset();
    e.byp = predict(1'b1);
    e.nob = predict(1'b0);
    exp_q.push_back(e);
    if (rn) model_edge();
  endtask

  task automatic idle_read(input int a1, input int a2);
    cycle(1, 0, 0, '0, 0, 0, 0, a1, a2);
  endtask

  task automatic chk_word(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response;
  // sample well after the falling-edge drive and before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_word("byp_rs1_data", b_rs1_data, e.byp.d1);
        chk_word("byp_rs2_data", b_rs2_data, e.byp.d2);
        chk_bit ("byp_rs1_busy", b_rs1_busy, e.byp.b1);
        chk_bit ("byp_rs2_busy", b_rs2_busy, e.byp.b2);
        chk_bit ("byp_clr_busy", b_clr_busy, e.byp.cb);
        chk_word("nob_rs1_data", n_rs1_data, e.nob.d1);
        chk_word("nob_rs2_data", n_rs2_data, e.nob.d2);
        chk_bit ("nob_rs1_busy", n_rs1_busy, e.nob.b1);
        chk_bit ("nob_rs2_busy", n_rs2_busy, e.nob.b2);
        chk_bit ("nob_clr_busy", n_clr_busy, e.nob.cb);
      end
    end
  end

  initial begin
    int wa, ia, a1, a2, guard;
    rst_n = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
    iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0; rs1_addr = '0; rs2_addr = '0;
    model_reset();

    // Reset, then read every address with the file idle.
    cycle(0, 0, 0, '0, 0, 0, 0, 3, 9);
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 31);
    for (int i = 0; i < NREGS; i++) idle_read(i, NREGS - 1 - i);

    // Same-cycle write/read of x5, then the following cycle.
    cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
    idle_read(5, 0);

    // Writes to x0 are discarded and x0 is never busy.
    cycle(1, 1, 0, 32'h12345678, 1, 0, 0, 0, 0);
    idle_read(0, 0);

    // Issue x7, writeback racing a re-issue, then a lone writeback.
    cycle(1, 0, 0, '0, 1, 7, 0, 7, 7);
    idle_read(7, 7);
    cycle(1, 1, 7, 32'h0000_0777, 1, 7, 0, 7, 7);
    idle_read(7, 7);
    cycle(1, 1, 7, 32'h0000_7777, 0, 0, 0, 7, 7);
    idle_read(7, 7);

    // Fill, soft clear with a dropped write and issue mid-clear, then read back.
    for (int i = 1; i < NREGS; i++) cycle(1, 1, i, 32'hA5000000 + i, i % 3 == 0, i, 0, i, i - 1);
    cycle(1, 0, 0, '0, 0, 0, 1, 1, 2);
    for (int i = 0; i < NREGS + 2; i++)
      cycle(1, i == 4, 3, 32'hBAD0_0003, i == 6, 9, i == 8, 3, i % NREGS);
    for (int i = 0; i < NREGS; i++) idle_read(i, NREGS - 1 - i);

    // Reset in the fourth clear cycle, then a fresh clear after a partial refill.
    for (int i = 1; i < NREGS; i++) cycle(1, 1, i, 32'h5A000000 + i, 0, 0, 0, i, 0);
    cycle(1, 0, 0, '0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) idle_read(i + 1, 4);
    cycle(0, 0, 0, '0, 0, 0, 0, 4, 5);
    idle_read(5, 31);
    for (int i = 1; i <= 8; i++) cycle(1, 1, i, 32'hC0DE0000 + i, 0, 0, 0, i, 0);
    cycle(1, 0, 0, '0, 0, 0, 1, 1, 2);
    for (int i = 0; i < NREGS + 1; i++) idle_read((i % 8) + 1, ((i + 1) % 8) + 1);

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 1500; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      ia = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? ia : int'($urandom_range(0, 7));
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 2) == 0, ia, $urandom_range(0, 79) == 0, a1, a2);
    end
    for (int i = 0; i < NREGS + 2; i++) idle_read(i % NREGS, (i + 7) % NREGS);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #4;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
